// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the conv window controller
package conv_pkg;

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DONE} conv_win_state_t;

  function automatic int pos_width(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - row/column wrap counter for incoming frame pixels
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int width  = 28,
  parameter int height = 28,
  parameter int pos_w  = 5
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [pos_w-1:0] o_row,
  output logic [pos_w-1:0] o_col,
  output logic             o_row_last,
  output logic             o_col_last
);

  localparam logic [pos_w-1:0] ROW_MAX = pos_w'(height - 1);
  localparam logic [pos_w-1:0] COL_MAX = pos_w'(width - 1);

  logic [pos_w-1:0] row_q, row_d;
  logic [pos_w-1:0] col_q, col_d;

  always_comb begin
    o_row      = row_q;
    o_col      = col_q;
    o_row_last = (row_q == ROW_MAX);
    o_col_last = (col_q == COL_MAX);
    row_d      = row_q;
    col_d      = col_q;
    if (i_inc) begin
      if (o_col_last) begin
        col_d = '0;
        row_d = o_row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - conv_ibuf write enable and kernel-window handshake control
// Optional stall counter enabled by CONV_WINDOW_CTRL_PERF_EN.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter  int img_width  = 28,
  parameter  int img_height = 28,
  parameter  int kernel_dim = 3,
  localparam int pos_w      = pos_width(img_width, img_height)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_ibuf_we,
  output logic             o_win_valid,
  input  logic             i_win_ready,
  output logic [pos_w-1:0] o_out_row,
  output logic [pos_w-1:0] o_out_col,
  output logic             o_frame_done,
  output logic [31:0]      o_stall_cycles
);

  localparam logic [pos_w-1:0] K_M1 = pos_w'(kernel_dim - 1);

  conv_win_state_t  state_q, state_d;
  logic [pos_w-1:0] out_row_q, out_row_d;
  logic [pos_w-1:0] out_col_q, out_col_d;
  logic             last_q, last_d;

  logic [pos_w-1:0] pix_row, pix_col;
  logic             row_last, col_last;
  logic             accept, window_hit, win_accept;

  conv_pos_counter #(
    .width (img_width),
    .height(img_height),
    .pos_w (pos_w)
  ) u_pos (
    .clk       (clk),
    .i_clr     (rst),
    .i_inc     (accept),
    .o_row     (pix_row),
    .o_col     (pix_col),
    .o_row_last(row_last),
    .o_col_last(col_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      out_row_q <= '0;
      out_col_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      last_q    <= last_d;
    end
  end

  // The first kernel_dim-1 rows/cols are gated out, so stale ibuf data never forms a window.
  always_comb begin
    window_hit = (pix_row >= K_M1) && (pix_col >= K_M1);
    win_accept = accept && window_hit;
    state_d    = state_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    last_d     = last_q;
    if (win_accept) begin
      out_row_d = pix_row - K_M1;
      out_col_d = pix_col - K_M1;
      last_d    = row_last && col_last;
    end
    case (state_q)
      S_RUN:  if (win_accept) state_d = S_HOLD;
      S_HOLD: begin
        if (i_win_ready) begin
          if (last_q)          state_d = S_DONE;
          else if (win_accept) state_d = S_HOLD;
          else                 state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    o_ready      = !rst && ((state_q == S_RUN) || ((state_q == S_HOLD) && i_win_ready));
    accept       = i_valid && o_ready;
    o_ibuf_we    = accept;
    o_win_valid  = (state_q == S_HOLD);
    o_frame_done = (state_q == S_DONE);
    o_out_row    = out_row_q;
    o_out_col    = out_col_q;
  end

`ifdef CONV_WINDOW_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (i_valid && !o_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule
